mem_req_arbiter: RTL

//  Shares one word-wide RAM port between the instruction and data requests of two

---
 rtl/mem_req_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_req_arbiter.sv
// Shares one RAM port between the instruction/data requests of two cores, one access at a time.
// Optional ARB_TIMEOUT_EN aborts an ACCESS after TIMEOUT_CYCLES cycles without ram_ready.
module mem_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          RR_INIT        = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iren_i,
  input  logic [1:0][31:0] iaddr_i,
  input  logic [1:0]       dren_i,
  input  logic [1:0]       dwen_i,
  input  logic [1:0][31:0] daddr_i,
  input  logic [1:0][31:0] dstore_i,
  output logic [1:0]       iwait_o,
  output logic [1:0]       dwait_o,
  output logic [1:0][31:0] iload_o,
  output logic [1:0][31:0] dload_o,
  output logic             ram_ren_o,
  output logic             ram_wen_o,
  output logic [31:0]      ram_addr_o,
  output logic [31:0]      ram_store_o,
  input  logic [31:0]      ram_load_i,
  input  logic             ram_ready_i,
  output logic [1:0]       arb_err_o
);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic        core_q, core_d;
  logic        dsrc_q, dsrc_d;
  logic        wen_q, wen_d;
  logic        rr_last_q, rr_last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;

  logic [1:0]  req;
  logic        pick;
  logic        timeout;
  logic        done;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535 to fit the 16-bit timeout counter");
  end

  assign req = iren_i | dren_i | dwen_i;

  // Round robin only matters on contention; a lone requester always wins.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) begin
      pick = ~rr_last_q;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign timeout = (state_q == StAccess) && !ram_ready_i &&
                   (cnt_q == 16'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (!ram_ready_i && !timeout) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    arb_err_o = '0;
    if (timeout) begin
      arb_err_o[core_q] = 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign arb_err_o = '0;
`endif

  assign done = (state_q == StAccess) && (ram_ready_i || timeout);

  always_comb begin
    state_d   = state_q;
    core_d    = core_q;
    dsrc_d    = dsrc_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    store_d   = store_q;
    rr_last_d = rr_last_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          core_d  = pick;
          dsrc_d  = dren_i[pick] | dwen_i[pick];
          wen_d   = dwen_i[pick];
          addr_d  = (dren_i[pick] | dwen_i[pick]) ? daddr_i[pick] : iaddr_i[pick];
          store_d = dstore_i[pick];
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (done) begin
          rr_last_d = core_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      core_q    <= 1'b0;
      dsrc_q    <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      store_q   <= '0;
      rr_last_q <= RR_INIT;
    end else begin
      state_q   <= state_d;
      core_q    <= core_d;
      dsrc_q    <= dsrc_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Strobes follow the registered state so an asynchronous reset drops them at once.
  always_comb begin
    ram_ren_o = (state_q == StAccess) && !wen_q && !timeout;
    ram_wen_o = (state_q == StAccess) && wen_q && !timeout;
    iwait_o   = 2'b11;
    dwait_o   = 2'b11;
    if (done) begin
      if (dsrc_q) begin
        dwait_o[core_q] = 1'b0;
      end else begin
        iwait_o[core_q] = 1'b0;
      end
    end
  end

  assign ram_addr_o  = addr_q;
  assign ram_store_o = store_q;
  assign iload_o     = {ram_load_i, ram_load_i};
  assign dload_o     = {ram_load_i, ram_load_i};

endmodule
